e203_exu_longp_wbbuf: RTL and testbench

- Long-pipe writeback buffer directly downstream of the OITF (outstanding instruction track FIFO).
- Captures out-of-order completions from the LSU and NICE long-pipe units, each tagged with the OITF dispatch pointer (itag).
- Drains them in program order at the OITF retire pointer, either to the regfile writeback arbiter or to the commit/exception path.
- Pulses oitf_ret_ena to pop the OITF entry.

---
 rtl/e203_longp_pkg.sv | 15 +
 rtl/e203_exu_longp_wbbuf_slot.sv | 45 ++++
 rtl/e203_exu_longp_wbbuf.sv | 111 +++++++++++
 tb/tb_e203_exu_longp_wbbuf.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_longp_pkg.sv
// Shared types and constants for the long-pipe writeback buffer.
// One buffer slot holds a completed result awaiting in-order retire.
package e203_longp_pkg;

   localparam int XLEN       = 32;
   localparam int RFIDX_W    = 5;
   localparam int OITF_DEPTH = 2;

   typedef struct packed {
      logic            vld;
      logic            err;
      logic [XLEN-1:0] wdat;
   } wbbuf_slot_t;

endpackage

// File: rtl/e203_exu_longp_wbbuf_slot.sv
// One writeback buffer slot: set on capture, cleared on retire.
// Only the valid bit is reset; payload is qualified by it.
module e203_exu_longp_wbbuf_slot
   import e203_longp_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_i,
   input  logic            clr_i,
   input  logic            err_i,
   input  logic [XLEN-1:0] wdat_i,
   output wbbuf_slot_t     slot_o
);

   logic            vld_q;
   logic            vld_d;
   logic            err_q;
   logic [XLEN-1:0] wdat_q;

   // next valid: capture and retire never hit the same slot together
   always_comb begin
      vld_d = vld_q;
      if (clr_i) vld_d = 1'b0;
      if (set_i) vld_d = 1'b1;
   end

   // valid bit with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= 1'b0;
      else        vld_q <= vld_d;
   end

   // payload registers, loaded only on capture
   always_ff @(posedge clk) begin
      if (set_i) begin
         wdat_q <= wdat_i;
         err_q  <= err_i;
      end
   end

   assign slot_o.vld  = vld_q;
   assign slot_o.err  = err_q;
   assign slot_o.wdat = wdat_q;

endmodule

// File: rtl/e203_exu_longp_wbbuf.sv
// Long-pipe writeback buffer: captures LSU/NICE completions by itag
// and drains them in program order at the OITF retire pointer.
module e203_exu_longp_wbbuf #(
   parameter  int OITF_DEPTH = e203_longp_pkg::OITF_DEPTH,
   parameter  int XLEN       = e203_longp_pkg::XLEN,
   parameter  int RFIDX_W    = e203_longp_pkg::RFIDX_W,
   localparam int PTR_W      = $clog2(OITF_DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               lsu_wbck_i_valid,
   output logic               lsu_wbck_i_ready,
   input  logic [XLEN-1:0]    lsu_wbck_i_wdat,
   input  logic [PTR_W-1:0]   lsu_wbck_i_itag,
   input  logic               lsu_wbck_i_err,
   input  logic               nice_wbck_i_valid,
   output logic               nice_wbck_i_ready,
   input  logic [XLEN-1:0]    nice_wbck_i_wdat,
   input  logic [PTR_W-1:0]   nice_wbck_i_itag,
   input  logic               nice_wbck_i_err,
   input  logic               oitf_empty,
   input  logic [PTR_W-1:0]   oitf_ret_ptr,
   input  logic [RFIDX_W-1:0] oitf_ret_rdidx,
   input  logic               oitf_ret_rdwen,
   input  logic               oitf_ret_rdfpu,
   input  logic [XLEN-1:0]    oitf_ret_pc,
   output logic               oitf_ret_ena,
   output logic               longp_wbck_o_valid,
   input  logic               longp_wbck_o_ready,
   output logic [XLEN-1:0]    longp_wbck_o_wdat,
   output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
   output logic               longp_wbck_o_rdfpu,
   output logic               longp_excp_o_valid,
   input  logic               longp_excp_o_ready,
   output logic [XLEN-1:0]    longp_excp_o_pc
);

   import e203_longp_pkg::*;

   wbbuf_slot_t           slot [OITF_DEPTH];
   logic [OITF_DEPTH-1:0] set;
   logic [OITF_DEPTH-1:0] clr;
   logic [OITF_DEPTH-1:0] sel_lsu;
   logic [OITF_DEPTH-1:0] slot_vld;
   logic                  same_tag;
   logic                  lsu_hsk;
   logic                  nice_hsk;
   wbbuf_slot_t           head;
   logic                  h;

   assign same_tag = lsu_wbck_i_valid
                   & (lsu_wbck_i_itag == nice_wbck_i_itag);

   assign lsu_wbck_i_ready  = ~slot[lsu_wbck_i_itag].vld;
   assign nice_wbck_i_ready = ~slot[nice_wbck_i_itag].vld & ~same_tag;

   assign lsu_hsk  = lsu_wbck_i_valid & lsu_wbck_i_ready;
   assign nice_hsk = nice_wbck_i_valid & nice_wbck_i_ready;

   assign head = slot[oitf_ret_ptr];
   assign h    = head.vld & ~oitf_empty;

   assign longp_excp_o_valid = h & head.err;
   assign longp_excp_o_pc    = oitf_ret_pc;

   assign longp_wbck_o_valid = h & ~head.err & oitf_ret_rdwen;
   assign longp_wbck_o_wdat  = head.wdat;
   assign longp_wbck_o_rdidx = oitf_ret_rdidx;
   assign longp_wbck_o_rdfpu = oitf_ret_rdfpu;

   assign oitf_ret_ena = h
      & ((longp_excp_o_valid & longp_excp_o_ready)
       | (longp_wbck_o_valid & longp_wbck_o_ready)
       | (~head.err & ~oitf_ret_rdwen));

   // per-slot capture/retire strobes decoded from itag and head ptr
   always_comb begin
      set      = '0;
      clr      = '0;
      sel_lsu  = '0;
      slot_vld = '0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
         sel_lsu[i]  = lsu_hsk & (lsu_wbck_i_itag == PTR_W'(i));
         set[i]      = sel_lsu[i]
                     | (nice_hsk & (nice_wbck_i_itag == PTR_W'(i)));
         clr[i]      = oitf_ret_ena & (oitf_ret_ptr == PTR_W'(i));
         slot_vld[i] = slot[i].vld;
      end
   end

   for (genvar g = 0; g < OITF_DEPTH; g++) begin : g_slot
      e203_exu_longp_wbbuf_slot u_slot (
         .clk    (clk),
         .rst_n  (rst_n),
         .set_i  (set[g]),
         .clr_i  (clr[g]),
         .err_i  (sel_lsu[g] ? lsu_wbck_i_err  : nice_wbck_i_err),
         .wdat_i (sel_lsu[g] ? lsu_wbck_i_wdat : nice_wbck_i_wdat),
         .slot_o (slot[g])
      );
   end

   a_empty_holds_nothing: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(oitf_empty && (|slot_vld)));

   a_single_request: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(longp_wbck_o_valid && longp_excp_o_valid));

endmodule

// File: tb/tb_e203_exu_longp_wbbuf.sv
// Directed bench for the long-pipe writeback buffer.
// Inputs change just after negedge; outputs are sampled 1ns later.
module tb_e203_exu_longp_wbbuf;

   localparam int XLEN    = 32;
   localparam int RFIDX_W = 5;
   localparam int PTR_W   = 1;

   logic               clk;
   logic               rst_n;
   logic               lsu_wbck_i_valid;
   logic               lsu_wbck_i_ready;
   logic [XLEN-1:0]    lsu_wbck_i_wdat;
   logic [PTR_W-1:0]   lsu_wbck_i_itag;
   logic               lsu_wbck_i_err;
   logic               nice_wbck_i_valid;
   logic               nice_wbck_i_ready;
   logic [XLEN-1:0]    nice_wbck_i_wdat;
   logic [PTR_W-1:0]   nice_wbck_i_itag;
   logic               nice_wbck_i_err;
   logic               oitf_empty;
   logic [PTR_W-1:0]   oitf_ret_ptr;
   logic [RFIDX_W-1:0] oitf_ret_rdidx;
   logic               oitf_ret_rdwen;
   logic               oitf_ret_rdfpu;
   logic [XLEN-1:0]    oitf_ret_pc;
   logic               oitf_ret_ena;
   logic               longp_wbck_o_valid;
   logic               longp_wbck_o_ready;
   logic [XLEN-1:0]    longp_wbck_o_wdat;
   logic [RFIDX_W-1:0] longp_wbck_o_rdidx;
   logic               longp_wbck_o_rdfpu;
   logic               longp_excp_o_valid;
   logic               longp_excp_o_ready;
   logic [XLEN-1:0]    longp_excp_o_pc;

   int n_cmp;
   int n_err;

   e203_exu_longp_wbbuf dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .lsu_wbck_i_valid   (lsu_wbck_i_valid),
      .lsu_wbck_i_ready   (lsu_wbck_i_ready),
      .lsu_wbck_i_wdat    (lsu_wbck_i_wdat),
      .lsu_wbck_i_itag    (lsu_wbck_i_itag),
      .lsu_wbck_i_err     (lsu_wbck_i_err),
      .nice_wbck_i_valid  (nice_wbck_i_valid),
      .nice_wbck_i_ready  (nice_wbck_i_ready),
      .nice_wbck_i_wdat   (nice_wbck_i_wdat),
      .nice_wbck_i_itag   (nice_wbck_i_itag),
      .nice_wbck_i_err    (nice_wbck_i_err),
      .oitf_empty         (oitf_empty),
      .oitf_ret_ptr       (oitf_ret_ptr),
      .oitf_ret_rdidx     (oitf_ret_rdidx),
      .oitf_ret_rdwen     (oitf_ret_rdwen),
      .oitf_ret_rdfpu     (oitf_ret_rdfpu),
      .oitf_ret_pc        (oitf_ret_pc),
      .oitf_ret_ena       (oitf_ret_ena),
      .longp_wbck_o_valid (longp_wbck_o_valid),
      .longp_wbck_o_ready (longp_wbck_o_ready),
      .longp_wbck_o_wdat  (longp_wbck_o_wdat),
      .longp_wbck_o_rdidx (longp_wbck_o_rdidx),
      .longp_wbck_o_rdfpu (longp_wbck_o_rdfpu),
      .longp_excp_o_valid (longp_excp_o_valid),
      .longp_excp_o_ready (longp_excp_o_ready),
      .longp_excp_o_pc    (longp_excp_o_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // both sources must never target the same slot in one cycle
   a_no_tag_clash: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(lsu_wbck_i_valid && nice_wbck_i_valid
        && lsu_wbck_i_itag == nice_wbck_i_itag));

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n              = 1'b0;
      lsu_wbck_i_valid   = 1'b0;
      lsu_wbck_i_wdat    = '0;
      lsu_wbck_i_itag    = '0;
      lsu_wbck_i_err     = 1'b0;
      nice_wbck_i_valid  = 1'b0;
      nice_wbck_i_wdat   = '0;
      nice_wbck_i_itag   = 1'b1;
      nice_wbck_i_err    = 1'b0;
      oitf_empty         = 1'b1;
      oitf_ret_ptr       = '0;
      oitf_ret_rdidx     = '0;
      oitf_ret_rdwen     = 1'b1;
      oitf_ret_rdfpu     = 1'b0;
      oitf_ret_pc        = '0;
      longp_wbck_o_ready = 1'b0;
      longp_excp_o_ready = 1'b0;
      #3;
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL rst_wbck_valid got=%b exp=0", longp_wbck_o_valid); end
      n_cmp++; if (longp_excp_o_valid !== 1'b0) begin n_err++;
         $display("FAIL rst_excp_valid got=%b exp=0", longp_excp_o_valid); end
      n_cmp++; if (oitf_ret_ena !== 1'b0) begin n_err++;
         $display("FAIL rst_ret_ena got=%b exp=0", oitf_ret_ena); end
      n_cmp++; if (lsu_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL rst_lsu_ready got=%b exp=1", lsu_wbck_i_ready); end
      n_cmp++; if (nice_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL rst_nice_ready got=%b exp=1", nice_wbck_i_ready); end
      nxt();
      rst_n      = 1'b1;
      oitf_empty = 1'b0;
   endtask

   task automatic test_in_order();
      nxt();
      oitf_ret_ptr       = 1'b0;
      oitf_ret_rdidx     = 5'd5;
      oitf_ret_rdwen     = 1'b1;
      oitf_ret_pc        = 32'h8000_0010;
      longp_wbck_o_ready = 1'b1;
      lsu_wbck_i_valid   = 1'b1;
      lsu_wbck_i_itag    = 1'b0;
      lsu_wbck_i_wdat    = 32'hDEAD_BEEF;
      lsu_wbck_i_err     = 1'b0;
      #1;
      n_cmp++; if (lsu_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL io_lsu_ready got=%b exp=1", lsu_wbck_i_ready); end
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL io_no_bypass got=%b exp=0", longp_wbck_o_valid); end
      nxt();
      lsu_wbck_i_valid = 1'b0;
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b1) begin n_err++;
         $display("FAIL io_wbck_valid got=%b exp=1", longp_wbck_o_valid); end
      n_cmp++; if (longp_wbck_o_wdat !== 32'hDEAD_BEEF) begin n_err++;
         $display("FAIL io_wdat got=%h exp=deadbeef", longp_wbck_o_wdat); end
      n_cmp++; if (longp_wbck_o_rdidx !== 5'd5) begin n_err++;
         $display("FAIL io_rdidx got=%0d exp=5", longp_wbck_o_rdidx); end
      n_cmp++; if (oitf_ret_ena !== 1'b1) begin n_err++;
         $display("FAIL io_ret_ena got=%b exp=1", oitf_ret_ena); end
      n_cmp++; if (longp_excp_o_valid !== 1'b0) begin n_err++;
         $display("FAIL io_excp_valid got=%b exp=0", longp_excp_o_valid); end
      n_cmp++; if (lsu_wbck_i_ready !== 1'b0) begin n_err++;
         $display("FAIL io_slot_full got=%b exp=0", lsu_wbck_i_ready); end
      nxt();
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL io_drained got=%b exp=0", longp_wbck_o_valid); end
      n_cmp++; if (oitf_ret_ena !== 1'b0) begin n_err++;
         $display("FAIL io_ret_done got=%b exp=0", oitf_ret_ena); end
      n_cmp++; if (lsu_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL io_slot_free got=%b exp=1", lsu_wbck_i_ready); end
   endtask

   task automatic test_out_of_order();
      nxt();
      oitf_ret_ptr       = 1'b0;
      oitf_ret_rdidx     = 5'd2;
      oitf_ret_rdfpu     = 1'b0;
      longp_wbck_o_ready = 1'b1;
      nice_wbck_i_valid  = 1'b1;
      nice_wbck_i_itag   = 1'b1;
      nice_wbck_i_wdat   = 32'h11;
      nice_wbck_i_err    = 1'b0;
      #1;
      n_cmp++; if (nice_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL ooo_nice_ready got=%b exp=1", nice_wbck_i_ready); end
      nxt();
      nice_wbck_i_valid = 1'b0;
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL ooo_wait1 got=%b exp=0", longp_wbck_o_valid); end
      n_cmp++; if (nice_wbck_i_ready !== 1'b0) begin n_err++;
         $display("FAIL ooo_slot1_full got=%b exp=0", nice_wbck_i_ready); end
      nxt();
      lsu_wbck_i_valid = 1'b1;
      lsu_wbck_i_itag  = 1'b0;
      lsu_wbck_i_wdat  = 32'h22;
      lsu_wbck_i_err   = 1'b0;
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL ooo_wait2 got=%b exp=0", longp_wbck_o_valid); end
      n_cmp++; if (oitf_ret_ena !== 1'b0) begin n_err++;
         $display("FAIL ooo_no_ret got=%b exp=0", oitf_ret_ena); end
      nxt();
      lsu_wbck_i_valid = 1'b0;
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b1) begin n_err++;
         $display("FAIL ooo_head0_valid got=%b exp=1", longp_wbck_o_valid); end
      n_cmp++; if (longp_wbck_o_wdat !== 32'h22) begin n_err++;
         $display("FAIL ooo_head0_wdat got=%h exp=22", longp_wbck_o_wdat); end
      nxt();
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL ooo_head0_gone got=%b exp=0", longp_wbck_o_valid); end
      oitf_ret_ptr   = 1'b1;
      oitf_ret_rdidx = 5'd7;
      oitf_ret_rdfpu = 1'b1;
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b1) begin n_err++;
         $display("FAIL ooo_head1_valid got=%b exp=1", longp_wbck_o_valid); end
      n_cmp++; if (longp_wbck_o_wdat !== 32'h11) begin n_err++;
         $display("FAIL ooo_head1_wdat got=%h exp=11", longp_wbck_o_wdat); end
      n_cmp++; if (longp_wbck_o_rdidx !== 5'd7) begin n_err++;
         $display("FAIL ooo_head1_rdidx got=%0d exp=7", longp_wbck_o_rdidx); end
      n_cmp++; if (longp_wbck_o_rdfpu !== 1'b1) begin n_err++;
         $display("FAIL ooo_head1_rdfpu got=%b exp=1", longp_wbck_o_rdfpu); end
      n_cmp++; if (oitf_ret_ena !== 1'b1) begin n_err++;
         $display("FAIL ooo_head1_ret got=%b exp=1", oitf_ret_ena); end
      nxt();
      #1;
      n_cmp++; if (nice_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL ooo_slot1_free got=%b exp=1", nice_wbck_i_ready); end
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL ooo_empty got=%b exp=0", longp_wbck_o_valid); end
      oitf_ret_ptr   = 1'b0;
      oitf_ret_rdfpu = 1'b0;
   endtask

   task automatic test_backpressure();
      nxt();
      oitf_ret_ptr       = 1'b0;
      oitf_ret_rdidx     = 5'd3;
      longp_wbck_o_ready = 1'b0;
      lsu_wbck_i_valid   = 1'b1;
      lsu_wbck_i_itag    = 1'b0;
      lsu_wbck_i_wdat    = 32'hCAFE_F00D;
      nxt();
      lsu_wbck_i_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (longp_wbck_o_valid !== 1'b1) begin n_err++;
            $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, longp_wbck_o_valid); end
         n_cmp++; if (longp_wbck_o_wdat !== 32'hCAFE_F00D) begin n_err++;
            $display("FAIL bp_hold_wdat c=%0d got=%h exp=cafef00d", c, longp_wbck_o_wdat); end
         n_cmp++; if (oitf_ret_ena !== 1'b0) begin n_err++;
            $display("FAIL bp_no_ret c=%0d got=%b exp=0", c, oitf_ret_ena); end
         n_cmp++; if (lsu_wbck_i_ready !== 1'b0) begin n_err++;
            $display("FAIL bp_lsu_blocked c=%0d got=%b exp=0", c, lsu_wbck_i_ready); end
         nxt();
      end
      longp_wbck_o_ready = 1'b1;
      #1;
      n_cmp++; if (oitf_ret_ena !== 1'b1) begin n_err++;
         $display("FAIL bp_release got=%b exp=1", oitf_ret_ena); end
      nxt();
      #1;
      n_cmp++; if (oitf_ret_ena !== 1'b0) begin n_err++;
         $display("FAIL bp_single_pulse got=%b exp=0", oitf_ret_ena); end
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL bp_drained got=%b exp=0", longp_wbck_o_valid); end
   endtask

   task automatic test_error();
      nxt();
      oitf_ret_ptr       = 1'b0;
      oitf_ret_rdwen     = 1'b1;
      oitf_ret_pc        = 32'h8000_0100;
      longp_wbck_o_ready = 1'b1;
      longp_excp_o_ready = 1'b0;
      lsu_wbck_i_valid   = 1'b1;
      lsu_wbck_i_itag    = 1'b0;
      lsu_wbck_i_wdat    = 32'h0BAD_0BAD;
      lsu_wbck_i_err     = 1'b1;
      nxt();
      lsu_wbck_i_valid = 1'b0;
      lsu_wbck_i_err   = 1'b0;
      #1;
      n_cmp++; if (longp_excp_o_valid !== 1'b1) begin n_err++;
         $display("FAIL err_excp_valid got=%b exp=1", longp_excp_o_valid); end
      n_cmp++; if (longp_excp_o_pc !== 32'h8000_0100) begin n_err++;
         $display("FAIL err_pc got=%h exp=80000100", longp_excp_o_pc); end
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL err_no_wbck got=%b exp=0", longp_wbck_o_valid); end
      n_cmp++; if (oitf_ret_ena !== 1'b0) begin n_err++;
         $display("FAIL err_wait got=%b exp=0", oitf_ret_ena); end
      longp_excp_o_ready = 1'b1;
      #1;
      n_cmp++; if (oitf_ret_ena !== 1'b1) begin n_err++;
         $display("FAIL err_ret got=%b exp=1", oitf_ret_ena); end
      nxt();
      #1;
      n_cmp++; if (longp_excp_o_valid !== 1'b0) begin n_err++;
         $display("FAIL err_drained got=%b exp=0", longp_excp_o_valid); end
      longp_excp_o_ready = 1'b0;
   endtask

   task automatic test_dual_capture();
      nxt();
      oitf_ret_ptr       = 1'b0;
      oitf_ret_rdwen     = 1'b0;
      longp_wbck_o_ready = 1'b0;
      lsu_wbck_i_valid   = 1'b1;
      lsu_wbck_i_itag    = 1'b0;
      lsu_wbck_i_wdat    = 32'h33;
      nice_wbck_i_valid  = 1'b1;
      nice_wbck_i_itag   = 1'b1;
      nice_wbck_i_wdat   = 32'h44;
      #1;
      n_cmp++; if (lsu_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL dual_lsu_ready got=%b exp=1", lsu_wbck_i_ready); end
      n_cmp++; if (nice_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL dual_nice_ready got=%b exp=1", nice_wbck_i_ready); end
      nxt();
      lsu_wbck_i_valid  = 1'b0;
      nice_wbck_i_valid = 1'b0;
      #1;
      n_cmp++; if (oitf_ret_ena !== 1'b1) begin n_err++;
         $display("FAIL dual_nord_ret got=%b exp=1", oitf_ret_ena); end
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL dual_nord_wbck got=%b exp=0", longp_wbck_o_valid); end
      n_cmp++; if (longp_excp_o_valid !== 1'b0) begin n_err++;
         $display("FAIL dual_nord_excp got=%b exp=0", longp_excp_o_valid); end
      nxt();
      #1;
      n_cmp++; if (lsu_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL dual_slot0_free got=%b exp=1", lsu_wbck_i_ready); end
      n_cmp++; if (nice_wbck_i_ready !== 1'b0) begin n_err++;
         $display("FAIL dual_slot1_held got=%b exp=0", nice_wbck_i_ready); end
      n_cmp++; if (oitf_ret_ena !== 1'b0) begin n_err++;
         $display("FAIL dual_head0_empty got=%b exp=0", oitf_ret_ena); end
      oitf_ret_ptr       = 1'b1;
      oitf_ret_rdwen     = 1'b1;
      oitf_ret_rdidx     = 5'd9;
      longp_wbck_o_ready = 1'b1;
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b1) begin n_err++;
         $display("FAIL dual_head1_valid got=%b exp=1", longp_wbck_o_valid); end
      n_cmp++; if (longp_wbck_o_wdat !== 32'h44) begin n_err++;
         $display("FAIL dual_head1_wdat got=%h exp=44", longp_wbck_o_wdat); end
      n_cmp++; if (longp_wbck_o_rdidx !== 5'd9) begin n_err++;
         $display("FAIL dual_head1_rdidx got=%0d exp=9", longp_wbck_o_rdidx); end
      nxt();
      #1;
      n_cmp++; if (nice_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL dual_slot1_free got=%b exp=1", nice_wbck_i_ready); end
      oitf_ret_ptr = 1'b0;
   endtask

   task automatic test_reset_mid();
      nxt();
      oitf_ret_ptr       = 1'b0;
      oitf_ret_rdwen     = 1'b1;
      longp_wbck_o_ready = 1'b0;
      lsu_wbck_i_valid   = 1'b1;
      lsu_wbck_i_itag    = 1'b0;
      lsu_wbck_i_wdat    = 32'h55;
      nice_wbck_i_valid  = 1'b1;
      nice_wbck_i_itag   = 1'b1;
      nice_wbck_i_wdat   = 32'h66;
      nxt();
      lsu_wbck_i_valid   = 1'b0;
      nice_wbck_i_valid  = 1'b0;
      longp_wbck_o_ready = 1'b1;
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b1) begin n_err++;
         $display("FAIL rm_pre_valid got=%b exp=1", longp_wbck_o_valid); end
      n_cmp++; if (oitf_ret_ena !== 1'b1) begin n_err++;
         $display("FAIL rm_pre_ret got=%b exp=1", oitf_ret_ena); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL rm_async_valid got=%b exp=0", longp_wbck_o_valid); end
      n_cmp++; if (oitf_ret_ena !== 1'b0) begin n_err++;
         $display("FAIL rm_async_ret got=%b exp=0", oitf_ret_ena); end
      nxt();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (lsu_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL rm_lsu_ready got=%b exp=1", lsu_wbck_i_ready); end
      n_cmp++; if (nice_wbck_i_ready !== 1'b1) begin n_err++;
         $display("FAIL rm_nice_ready got=%b exp=1", nice_wbck_i_ready); end
      n_cmp++; if (longp_wbck_o_valid !== 1'b0) begin n_err++;
         $display("FAIL rm_post_valid got=%b exp=0", longp_wbck_o_valid); end
      longp_wbck_o_ready = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_in_order();
      test_out_of_order();
      test_backpressure();
      test_error();
      test_dual_capture();
      test_reset_mid();
      nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
